// File: rtl/key_step_debouncer.sv
// Push-button conditioner: 2-flop synchronisers, press/release debounce FSM, one-cycle step strobe.
// Optional auto-repeat while held is enabled by defining AUTOREPEAT_EN.
module key_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic sw_dir,
  output logic step,
  output logic dir,
  output logic pressed
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [1:0]    key_sync_q, key_sync_d;
  logic [1:0]    dir_sync_q, dir_sync_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          pressed_q, pressed_d;
  logic          key_s, dir_s;

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          first_q, first_d;
`endif

  assign key_s = key_sync_q[1];
  assign dir_s = dir_sync_q[1];

  always_comb begin
    key_sync_d = {key_sync_q[0], key_n};
    dir_sync_d = {dir_sync_q[0], sw_dir};
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
`ifdef AUTOREPEAT_EN
    rpt_d      = rpt_q;
    first_d    = first_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          step_d  = 1'b1;
          dir_d   = dir_s;
`ifdef AUTOREPEAT_EN
          rpt_d   = '0;
          first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef AUTOREPEAT_EN
        // First repeat waits REPEAT_DELAY after acceptance, the rest REPEAT_PERIOD.
        else if (rpt_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
          step_d  = 1'b1;
          dir_d   = dir_s;
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
`ifdef AUTOREPEAT_EN
          rpt_d   = '0;
          first_d = 1'b1;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
`ifdef AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync_q <= 2'b11;
      dir_sync_q <= 2'b00;
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      pressed_q  <= 1'b0;
`ifdef AUTOREPEAT_EN
      rpt_q      <= '0;
      first_q    <= 1'b1;
`endif
    end else begin
      key_sync_q <= key_sync_d;
      dir_sync_q <= dir_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      pressed_q  <= pressed_d;
`ifdef AUTOREPEAT_EN
      rpt_q      <= rpt_d;
      first_q    <= first_d;
`endif
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign pressed = pressed_q;

endmodule
